// File: rtl/alu_n_seq.sv
// Sequential N-bit ALU with a start/done handshake, iterative shifts and registered N/Z/C/V flags.
// Optional build macro ALU_N_SEQ_MUL_EN turns op 111 into an unsigned shift-add multiply.
module alu_n_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [WIDTH:0]   W_VAL    = (WIDTH + 1)'(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SHR = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             n_q, n_d;
  logic             z_q, z_d;
  logic             fc_q, fc_d;
  logic             fv_q, fv_d;
  logic             done_q, done_d;

`ifdef ALU_N_SEQ_MUL_EN
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH:0]     psum;
`endif

  logic [WIDTH:0] sum_w;
  logic [WIDTH:0] dif_w;

  assign sum_w = {1'b0, a_q} + {1'b0, b_q};
  assign dif_w = {1'b0, a_q} - {1'b0, b_q};

  // Number of EXEC iterations for a new request; shifts clamp at WIDTH steps.
  function automatic logic [CNT_W-1:0] exec_steps(input logic [2:0] o,
                                                  input logic [WIDTH-1:0] amt);
    logic [CNT_W-1:0] n;
    n = CNT_ONE;
    if (o == OP_SHR || o == OP_SHL) begin
      if ({1'b0, amt} >= W_VAL) n = CNT_FULL;
      else                      n = CNT_W'(amt);
    end
`ifdef ALU_N_SEQ_MUL_EN
    else if (o == OP_MUL) begin
      n = CNT_FULL;
    end
`endif
    return n;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      n_q      <= 1'b0;
      z_q      <= 1'b0;
      fc_q     <= 1'b0;
      fv_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef ALU_N_SEQ_MUL_EN
      prod_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      v_q      <= v_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      n_q      <= n_d;
      z_q      <= z_d;
      fc_q     <= fc_d;
      fv_q     <= fv_d;
      done_q   <= done_d;
`ifdef ALU_N_SEQ_MUL_EN
      prod_q   <= prod_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    c_d      = c_q;
    v_d      = v_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    n_d      = n_q;
    z_d      = z_q;
    fc_d     = fc_q;
    fv_d     = fv_q;
    done_d   = 1'b0;
`ifdef ALU_N_SEQ_MUL_EN
    prod_d   = prod_q;
    psum     = '0;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = a;
          b_d     = b;
          acc_d   = a;
          c_d     = 1'b0;
          v_d     = 1'b0;
          cnt_d   = exec_steps(op, b);
          state_d = S_EXEC;
`ifdef ALU_N_SEQ_MUL_EN
          prod_d  = {{WIDTH{1'b0}}, b};
`endif
        end
      end

      S_EXEC: begin
        state_d = S_DONE;
        case (op_q)
          OP_ADD: begin
            acc_d = sum_w[WIDTH-1:0];
            c_d   = sum_w[WIDTH];
            v_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_w[WIDTH-1] != a_q[WIDTH-1]);
          end
          OP_SUB: begin
            acc_d = dif_w[WIDTH-1:0];
            c_d   = dif_w[WIDTH];
            v_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_w[WIDTH-1] != a_q[WIDTH-1]);
          end
          OP_SHR, OP_SHL: begin
            // One bit per cycle; a zero count still spends one EXEC cycle with C=0.
            if (cnt_q != '0) begin
              if (op_q == OP_SHR) begin
                acc_d = {1'b0, acc_q[WIDTH-1:1]};
                c_d   = acc_q[0];
              end else begin
                acc_d = {acc_q[WIDTH-2:0], 1'b0};
                c_d   = acc_q[WIDTH-1];
              end
              cnt_d = cnt_q - CNT_ONE;
            end
            if (cnt_q > CNT_ONE) state_d = S_EXEC;
          end
          OP_AND: acc_d = a_q & b_q;
          OP_OR:  acc_d = a_q | b_q;
          OP_XOR: acc_d = a_q ^ b_q;
          default: begin
`ifdef ALU_N_SEQ_MUL_EN
            // Shift-add: add A into the high half when the current multiplier bit is set.
            psum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : {WIDTH{1'b0}})};
            prod_d = {psum, prod_q[WIDTH-1:1]};
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q > CNT_ONE) state_d = S_EXEC;
`else
            acc_d = '0;
            c_d   = 1'b0;
            v_d   = 1'b0;
`endif
          end
        endcase
      end

      S_DONE: begin
        result_d = acc_q;
        fc_d     = c_q;
        fv_d     = v_q;
`ifdef ALU_N_SEQ_MUL_EN
        if (op_q == OP_MUL) begin
          result_d = prod_q[WIDTH-1:0];
          fc_d     = |prod_q[2*WIDTH-1:WIDTH];
          fv_d     = |prod_q[2*WIDTH-1:WIDTH];
        end
`endif
        n_d     = result_d[WIDTH-1];
        z_d     = (result_d == '0);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign result = result_q;
  assign flag_n = n_q;
  assign flag_z = z_q;
  assign flag_c = fc_q;
  assign flag_v = fv_q;
  assign done   = done_q;
  assign busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_n_seq.sv
// Bench for alu_n_seq (WIDTH=4): directed plan items plus random ops against an arithmetic model.
module tb_alu_n_seq;
  localparam int W    = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [2:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] result;
  logic         flag_n, flag_z, flag_c, flag_v, busy, done;

  int checks = 0;
  int failures = 0;

  alu_n_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .result(result), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
    .flag_v(flag_v), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int to_signed(input int v);
    return (v >= (1 << (W - 1))) ? v - (1 << W) : v;
  endfunction

  // Reference behaviour straight from the operation definitions.
  task automatic model(input int o, input int av, input int bv,
                       output int res, output int c, output int v, output int lat);
    int k, s;
    c = 0; v = 0; lat = 2; res = 0;
    k = (bv < W) ? bv : W;
    case (o)
      0: begin
        s = av + bv; res = s & MASK; c = (s > MASK) ? 1 : 0;
        s = to_signed(av) + to_signed(bv);
        v = (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
      end
      1: begin
        res = (av - bv) & MASK; c = (av < bv) ? 1 : 0;
        s = to_signed(av) - to_signed(bv);
        v = (s > (1 << (W - 1)) - 1 || s < -(1 << (W - 1))) ? 1 : 0;
      end
      2: begin
        res = av >> k; c = (k == 0) ? 0 : (av >> (k - 1)) & 1;
        lat = ((k < 1) ? 1 : k) + 1;
      end
      3: begin
        res = (av << k) & MASK; c = (k == 0) ? 0 : (av >> (W - k)) & 1;
        lat = ((k < 1) ? 1 : k) + 1;
      end
      4: res = av & bv;
      5: res = av | bv;
      6: res = av ^ bv;
      default: begin
`ifdef ALU_N_SEQ_MUL_EN
        s = av * bv; res = s & MASK;
        c = ((s >> W) != 0) ? 1 : 0; v = c; lat = W + 1;
`else
        res = 0;
`endif
      end
    endcase
  endtask

  // Issue one op, optionally poking start again while busy; check latency, outputs and hold.
  task automatic run_op(input int o, input int av, input int bv, input string tag, input bit poke);
    int er, ec, ev, el, lat, extra;
    model(o, av, bv, er, ec, ev, el);
    @(negedge clk);
    op = 3'(o); a = W'(av); b = W'(bv); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy"}, int'(busy), 1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      if (poke && i == 1) begin
        @(negedge clk); start = 1'b1; op = 3'd0; a = W'(1); b = W'(1);
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin lat = i; break; end
    end
    check({tag, ".latency"}, lat, el);
    check({tag, ".result"}, int'(result), er);
    check({tag, ".n"}, int'(flag_n), (er >> (W - 1)) & 1);
    check({tag, ".z"}, int'(flag_z), (er == 0) ? 1 : 0);
    check({tag, ".c"}, int'(flag_c), ec);
    check({tag, ".v"}, int'(flag_v), ev);
    check({tag, ".busy_at_done"}, int'(busy), 0);
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, int'(done), 0);
    check({tag, ".hold"}, int'(result), er);
    if (poke) begin
      extra = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (done) extra++;
      end
      check({tag, ".no_second_done"}, extra, 0);
    end
  endtask

  initial begin
    int seen;
    repeat (2) @(posedge clk);
    #1;
    check("reset.result", int'(result), 0);
    check("reset.flags", int'({flag_n, flag_z, flag_c, flag_v}), 0);
    check("reset.busy", int'(busy), 0);
    check("reset.done", int'(done), 0);
    @(negedge clk); rst = 1'b0;

    run_op(0, 9, 8, "add9_8", 0);
    run_op(0, 3, 4, "add3_4", 0);
    run_op(1, 3, 5, "sub3_5", 0);
    run_op(1, 5, 5, "sub5_5", 0);
    run_op(3, 3, 2, "shl3_2", 0);
    run_op(3, 3, 5, "shl3_5", 0);
    run_op(2, 5, 0, "shr5_0", 0);
    run_op(2, 8, 3, "shr8_3_poke", 1);
    run_op(7, 5, 3, "op7_5_3", 0);
    run_op(7, 5, 4, "op7_5_4", 0);
    run_op(6, 12, 10, "xor", 0);

    // Reset in the middle of a shift aborts it with no done.
    @(negedge clk);
    op = 3'd3; a = W'(1); b = W'(3); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("midrst.result", int'(result), 0);
    check("midrst.flags", int'({flag_n, flag_z, flag_c, flag_v}), 0);
    check("midrst.busy", int'(busy), 0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("midrst.no_done", seen, 0);
    run_op(0, 2, 2, "add2_2_after_rst", 0);

    for (int n = 0; n < 40; n++) begin
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, MASK)),
             int'($urandom_range(0, MASK)), $sformatf("rand%0d", n), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
